// File: rtl/gpio_apb_bank_pkg.sv
// Shared definitions for the GPIO expander banks: register map and the
// state encoding of the APB response sequencer.
package gpio_bank_pkg;

  localparam logic [2:0] ADDR_DATA_OUT   = 3'd0;
  localparam logic [2:0] ADDR_DIR        = 3'd1;
  localparam logic [2:0] ADDR_DATA_IN    = 3'd2;
  localparam logic [2:0] ADDR_RISE_EN    = 3'd3;
  localparam logic [2:0] ADDR_FALL_EN    = 3'd4;
  localparam logic [2:0] ADDR_IRQ_STATUS = 3'd5;
  localparam logic [2:0] ADDR_OUT_SET    = 3'd6;
  localparam logic [2:0] ADDR_OUT_CLR    = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } bank_state_e;

endpackage

// File: rtl/gpio_apb_bank_if.sv
// APB completer-side bus bundle for one GPIO bank (psel is this bank's bit
// of the bridge's select vector).
interface gpio_apb_bank_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready
  );
endinterface

// File: rtl/gpio_apb_bank_sync_edge.sv
// Two-flop pin synchroniser followed by a history register, giving the
// synchronised level and single-cycle rise/fall pulses per pin.
module gpio_sync_edge #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);
  logic [WIDTH-1:0] meta_p0;
  logic [WIDTH-1:0] sync_p1;
  logic [WIDTH-1:0] prev_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= '0;
      sync_p1 <= '0;
      prev_p2 <= '0;
    end else begin
      // p0: metastability catcher, p1: clean level, p2: last clean level
      meta_p0 <= pin;
      sync_p1 <= meta_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign sync = sync_p1;
  assign rise = sync_p1 & ~prev_p2;
  assign fall = ~sync_p1 & prev_p2;
endmodule

// File: rtl/gpio_apb_bank.sv
// One GPIO bank behind the SPI-to-APB bridge: output, direction and edge
// interrupt registers, answered over APB with WAIT_STATES extra cycles.
module gpio_apb_bank
  import gpio_bank_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 3,
  parameter int WAIT_STATES = 0
) (
  input  logic                  pclk,
  input  logic                  presetn,
  gpio_apb_bank_if.slave        apb,
  input  logic [DATA_WIDTH-1:0] gpio_i,
  output logic [DATA_WIDTH-1:0] gpio_o,
  output logic [DATA_WIDTH-1:0] gpio_oe,
  output logic                  irq
);
  // With WAIT_STATES = 0 the WAIT state is never entered, so this value is unused.
  localparam logic [2:0] WAIT_LAST = 3'(WAIT_STATES - 1);

  bank_state_e           state_q;
  bank_state_e           state_d;
  logic [2:0]            wait_cnt_q;
  logic [2:0]            wait_cnt_d;
  logic                  setup_phase;
  logic                  enter_resp;
  logic                  wr_commit;
  logic [2:0]            reg_sel;

  logic [DATA_WIDTH-1:0] data_out_q;
  logic [DATA_WIDTH-1:0] dir_q;
  logic [DATA_WIDTH-1:0] rise_en_q;
  logic [DATA_WIDTH-1:0] fall_en_q;
  logic [DATA_WIDTH-1:0] irq_status_q;
  logic [DATA_WIDTH-1:0] data_out_d;
  logic [DATA_WIDTH-1:0] w1c_mask;
  logic [DATA_WIDTH-1:0] hw_set;
  logic [DATA_WIDTH-1:0] rd_mux;

  logic [DATA_WIDTH-1:0] pin_sync;
  logic [DATA_WIDTH-1:0] pin_rise;
  logic [DATA_WIDTH-1:0] pin_fall;

  logic                  pready_q;
  logic [DATA_WIDTH-1:0] prdata_q;

  gpio_sync_edge #(
    .WIDTH (DATA_WIDTH)
  ) u_sync (
    .clk   (pclk),
    .rst_n (presetn),
    .pin   (gpio_i),
    .sync  (pin_sync),
    .rise  (pin_rise),
    .fall  (pin_fall)
  );

  assign setup_phase = apb.psel & ~apb.penable;
  assign reg_sel     = 3'(apb.paddr);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (setup_phase) begin
          wait_cnt_d = '0;
          state_d    = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q + 3'd1;
        if (!apb.psel) begin
          state_d = ST_IDLE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Read data is captured on the way into RESP, so it reflects the registers
  // at that edge; a withdrawn psel in RESP suppresses the write.
  assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
  assign wr_commit  = (state_q == ST_RESP) && apb.psel && apb.pwrite;

  always_comb begin
    rd_mux = '0;
    unique case (reg_sel)
      ADDR_DATA_OUT:   rd_mux = data_out_q;
      ADDR_DIR:        rd_mux = dir_q;
      ADDR_DATA_IN:    rd_mux = pin_sync;
      ADDR_RISE_EN:    rd_mux = rise_en_q;
      ADDR_FALL_EN:    rd_mux = fall_en_q;
      ADDR_IRQ_STATUS: rd_mux = irq_status_q;
      default:         rd_mux = '0;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      pready_q <= 1'b0;
      prdata_q <= '0;
    end else begin
      pready_q <= enter_resp;
      prdata_q <= enter_resp ? rd_mux : '0;
    end
  end

  always_comb begin
    data_out_d = data_out_q;
    w1c_mask   = '0;
    if (wr_commit) begin
      unique case (reg_sel)
        ADDR_DATA_OUT:   data_out_d = apb.pwdata;
        ADDR_OUT_SET:    data_out_d = data_out_q | apb.pwdata;
        ADDR_OUT_CLR:    data_out_d = data_out_q & ~apb.pwdata;
        ADDR_IRQ_STATUS: w1c_mask   = apb.pwdata;
        default:         data_out_d = data_out_q;
      endcase
    end
  end

  // Edge detection ignores DIR; a hardware set beats a same-cycle W1C.
  assign hw_set = (pin_rise & rise_en_q) | (pin_fall & fall_en_q);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      data_out_q   <= '0;
      dir_q        <= '0;
      rise_en_q    <= '0;
      fall_en_q    <= '0;
      irq_status_q <= '0;
    end else begin
      data_out_q   <= data_out_d;
      irq_status_q <= (irq_status_q & ~w1c_mask) | hw_set;
      if (wr_commit && reg_sel == ADDR_DIR)     dir_q     <= apb.pwdata;
      if (wr_commit && reg_sel == ADDR_RISE_EN) rise_en_q <= apb.pwdata;
      if (wr_commit && reg_sel == ADDR_FALL_EN) fall_en_q <= apb.pwdata;
    end
  end

  assign apb.pready = pready_q;
  assign apb.prdata = prdata_q;
  assign gpio_o     = data_out_q;
  assign gpio_oe    = dir_q;
  assign irq        = |irq_status_q;
endmodule

// File: tb/tb_gpio_apb_bank.sv
// Bench for gpio_apb_bank: a zero-wait and a three-wait instance share the pins
// and are checked every cycle against a transaction-level register model.
module tb_gpio_apb_bank;
  import gpio_bank_pkg::*;

  localparam int DW  = 8;
  localparam int AW  = 3;
  localparam int WS0 = 0;
  localparam int WS1 = 3;

  logic          pclk = 1'b0;
  logic          presetn = 1'b0;
  logic [DW-1:0] gpio_i = '0;
  logic [DW-1:0] gpio_o0, gpio_oe0, gpio_o1, gpio_oe1;
  logic          irq0, irq1;

  logic          psel_d[2];
  logic          penable_d[2];
  logic          pwrite_d[2];
  logic [AW-1:0] paddr_d[2];
  logic [DW-1:0] pwdata_d[2];

  int n_cmp = 0;
  int n_fail = 0;

  gpio_apb_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
  gpio_apb_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

  assign bus0.psel    = psel_d[0];
  assign bus0.penable = penable_d[0];
  assign bus0.pwrite  = pwrite_d[0];
  assign bus0.paddr   = paddr_d[0];
  assign bus0.pwdata  = pwdata_d[0];
  assign bus1.psel    = psel_d[1];
  assign bus1.penable = penable_d[1];
  assign bus1.pwrite  = pwrite_d[1];
  assign bus1.paddr   = paddr_d[1];
  assign bus1.pwdata  = pwdata_d[1];

  gpio_apb_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(WS0)) dut0 (
    .pclk(pclk), .presetn(presetn), .apb(bus0), .gpio_i(gpio_i),
    .gpio_o(gpio_o0), .gpio_oe(gpio_oe0), .irq(irq0));

  gpio_apb_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(WS1)) dut1 (
    .pclk(pclk), .presetn(presetn), .apb(bus1), .gpio_i(gpio_i),
    .gpio_o(gpio_o1), .gpio_oe(gpio_oe1), .irq(irq1));

  always #5 pclk = ~pclk;

  function automatic logic get_pready(input int k);
    return (k == 0) ? bus0.pready : bus1.pready;
  endfunction
  function automatic logic [DW-1:0] get_prdata(input int k);
    return (k == 0) ? bus0.prdata : bus1.prdata;
  endfunction
  function automatic logic [DW-1:0] get_gpio_o(input int k);
    return (k == 0) ? gpio_o0 : gpio_o1;
  endfunction
  function automatic logic [DW-1:0] get_gpio_oe(input int k);
    return (k == 0) ? gpio_oe0 : gpio_oe1;
  endfunction
  function automatic logic get_irq(input int k);
    return (k == 0) ? irq0 : irq1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // hist[n] = gpio_i as sampled n+1 clock edges ago; DATA_IN lags the pin by
  // two edges and an edge is judged between the two-edge and three-edge samples.
  logic [DW-1:0] hist[3];
  logic [DW-1:0] m_dout[2], m_dir[2], m_ren[2], m_fen[2], m_ist[2], m_prdata[2];
  bit            m_pready[2];
  bit            t_busy[2];
  int            t_age[2];

  function automatic logic [DW-1:0] m_read(input int k, input logic [2:0] a);
    case (a)
      ADDR_DATA_OUT:   return m_dout[k];
      ADDR_DIR:        return m_dir[k];
      ADDR_DATA_IN:    return hist[1];
      ADDR_RISE_EN:    return m_ren[k];
      ADDR_FALL_EN:    return m_fen[k];
      ADDR_IRQ_STATUS: return m_ist[k];
      default:         return '0;
    endcase
  endfunction

  initial begin : model
    logic [DW-1:0] set_b, w1c_b;
    int ws;
    forever begin
      @(posedge pclk or negedge presetn);
      if (!presetn) begin
        for (int k = 0; k < 2; k++) begin
          m_dout[k] = '0; m_dir[k] = '0; m_ren[k] = '0; m_fen[k] = '0; m_ist[k] = '0;
          m_prdata[k] = '0; m_pready[k] = 1'b0; t_busy[k] = 1'b0; t_age[k] = 0;
        end
        for (int i = 0; i < 3; i++) hist[i] = '0;
      end else begin
        for (int k = 0; k < 2; k++) begin
          ws = (k == 0) ? WS0 : WS1;
          set_b = (hist[1] & ~hist[2] & m_ren[k]) | (~hist[1] & hist[2] & m_fen[k]);
          w1c_b = '0;
          m_pready[k] = 1'b0;
          m_prdata[k] = '0;
          if (!t_busy[k] && psel_d[k] && !penable_d[k]) begin
            t_busy[k] = 1'b1;
            t_age[k]  = 0;
          end
          if (t_busy[k]) begin
            if (!psel_d[k]) begin
              t_busy[k] = 1'b0;
            end else if (t_age[k] == ws) begin
              m_pready[k] = 1'b1;
              m_prdata[k] = m_read(k, paddr_d[k]);
              t_age[k]++;
            end else if (t_age[k] == ws + 1) begin
              t_busy[k] = 1'b0;
              if (pwrite_d[k]) begin
                case (paddr_d[k])
                  ADDR_DATA_OUT:   m_dout[k] = pwdata_d[k];
                  ADDR_DIR:        m_dir[k]  = pwdata_d[k];
                  ADDR_RISE_EN:    m_ren[k]  = pwdata_d[k];
                  ADDR_FALL_EN:    m_fen[k]  = pwdata_d[k];
                  ADDR_IRQ_STATUS: w1c_b     = pwdata_d[k];
                  ADDR_OUT_SET:    m_dout[k] = m_dout[k] | pwdata_d[k];
                  ADDR_OUT_CLR:    m_dout[k] = m_dout[k] & ~pwdata_d[k];
                  default: ;
                endcase
              end
            end else begin
              t_age[k]++;
            end
          end
          m_ist[k] = (m_ist[k] & ~w1c_b) | set_b;
        end
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = gpio_i;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge pclk);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("pready[%0d]", k),  32'(get_pready(k)),  32'(m_pready[k]));
        chk($sformatf("prdata[%0d]", k),  32'(get_prdata(k)),  32'(m_prdata[k]));
        chk($sformatf("gpio_o[%0d]", k),  32'(get_gpio_o(k)),  32'(m_dout[k]));
        chk($sformatf("gpio_oe[%0d]", k), 32'(get_gpio_oe(k)), 32'(m_dir[k]));
        chk($sformatf("irq[%0d]", k),     32'(get_irq(k)),     32'(|m_ist[k]));
      end
    end
  end

  // ---------------- bus driver ----------------
  // abort_at = c drops psel at the start of access cycle c; lat = access cycle
  // in which pready was first seen, -1 if never.
  task automatic apb(input int k, input bit wr, input logic [2:0] a, input logic [DW-1:0] d,
                     input int abort_at, output logic [DW-1:0] rd, output int lat);
    int ws;
    ws  = (k == 0) ? WS0 : WS1;
    rd  = '0;
    lat = -1;
    @(posedge pclk); #1;
    psel_d[k] = 1'b1; penable_d[k] = 1'b0; pwrite_d[k] = wr; paddr_d[k] = a; pwdata_d[k] = d;
    @(posedge pclk); #1;
    penable_d[k] = 1'b1;
    for (int c = 0; c <= ws; c++) begin
      if (c == abort_at) break;
      @(negedge pclk);
      if (get_pready(k) && lat < 0) begin
        lat = c;
        rd  = get_prdata(k);
      end
      @(posedge pclk); #1;
    end
    psel_d[k] = 1'b0; penable_d[k] = 1'b0; pwrite_d[k] = 1'b0;
  endtask

  task automatic wr_reg(input int k, input logic [2:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] rd;
    int lat;
    apb(k, 1'b1, a, d, -1, rd, lat);
  endtask

  task automatic rd_reg(input int k, input logic [2:0] a, output logic [DW-1:0] d);
    int lat;
    apb(k, 1'b0, a, '0, -1, d, lat);
  endtask

  task automatic rand_txns(input int k, input int n);
    logic [DW-1:0] rd;
    int lat, ab;
    for (int i = 0; i < n; i++) begin
      ab = -1;
      if (k == 1 && $urandom_range(0, 5) == 0) ab = int'($urandom_range(0, 3));
      apb(k, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), DW'($urandom), ab, rd, lat);
      repeat ($urandom_range(0, 2)) @(posedge pclk);
    end
  endtask

  initial begin : stimulus
    logic [DW-1:0] rd;
    int lat;
    for (int k = 0; k < 2; k++) begin
      psel_d[k] = 1'b0; penable_d[k] = 1'b0; pwrite_d[k] = 1'b0;
      paddr_d[k] = '0; pwdata_d[k] = '0;
    end
    repeat (3) @(posedge pclk);
    #1 presetn = 1'b1;
    chk("rst_gpio_o",  32'(gpio_o0),     32'h00);
    chk("rst_gpio_oe", 32'(gpio_oe0),    32'h00);
    chk("rst_pready",  32'(bus0.pready), 32'h0);
    chk("rst_irq",     32'(irq1),        32'h0);

    // zero-wait write/read
    wr_reg(0, ADDR_DIR, 8'hF0);
    wr_reg(0, ADDR_DATA_OUT, 8'hA5);
    chk("dir_oe",  32'(gpio_oe0), 32'hF0);
    chk("dout_o",  32'(gpio_o0),  32'hA5);
    apb(0, 1'b0, ADDR_DATA_OUT, '0, -1, rd, lat);
    chk("rd_dout", 32'(rd), 32'hA5);
    chk("rd_lat0", 32'(lat), 32'd0);

    // set / clear
    wr_reg(0, ADDR_OUT_SET, 8'h0A);
    chk("out_set", 32'(gpio_o0), 32'hAF);
    wr_reg(0, ADDR_OUT_CLR, 8'h81);
    chk("out_clr", 32'(gpio_o0), 32'h2E);
    rd_reg(0, ADDR_OUT_SET, rd);
    chk("rd_set0", 32'(rd), 32'h00);
    rd_reg(0, ADDR_OUT_CLR, rd);
    chk("rd_clr0", 32'(rd), 32'h00);

    // input path and interrupts
    wr_reg(0, ADDR_RISE_EN, 8'h01);
    wr_reg(0, ADDR_FALL_EN, 8'h80);
    @(posedge pclk); #1 gpio_i = 8'h81;
    rd_reg(0, ADDR_DATA_IN, rd);
    chk("din_early", 32'(rd), 32'h00);
    rd_reg(0, ADDR_DATA_IN, rd);
    chk("din_late", 32'(rd), 32'h81);
    rd_reg(0, ADDR_IRQ_STATUS, rd);
    chk("ist_rise", 32'(rd), 32'h01);
    chk("irq_on", 32'(irq0), 32'h1);
    gpio_i = 8'h00;
    repeat (4) @(posedge pclk);
    rd_reg(0, ADDR_IRQ_STATUS, rd);
    chk("ist_fall", 32'(rd), 32'h81);
    wr_reg(0, ADDR_IRQ_STATUS, 8'h01);
    rd_reg(0, ADDR_IRQ_STATUS, rd);
    chk("ist_w1c0", 32'(rd), 32'h80);
    wr_reg(0, ADDR_IRQ_STATUS, 8'h80);
    rd_reg(0, ADDR_IRQ_STATUS, rd);
    chk("ist_w1c7", 32'(rd), 32'h00);
    chk("irq_off", 32'(irq0), 32'h0);

    // rise on pin 0 lands on the same edge as the W1C of bit 0
    gpio_i = 8'h01;
    repeat (5) @(posedge pclk);
    #1 gpio_i = 8'h00;
    repeat (5) @(posedge pclk);
    #1 gpio_i = 8'h01;
    wr_reg(0, ADDR_IRQ_STATUS, 8'h01);
    rd_reg(0, ADDR_IRQ_STATUS, rd);
    chk("race_set_wins", 32'(rd), 32'h01);

    // three wait states, then an aborted write
    wr_reg(1, ADDR_DIR, 8'hF0);
    apb(1, 1'b0, ADDR_DIR, '0, -1, rd, lat);
    chk("ws3_rd", 32'(rd), 32'hF0);
    chk("ws3_lat", 32'(lat), 32'd3);
    wr_reg(1, ADDR_DATA_OUT, 8'h33);
    apb(1, 1'b1, ADDR_DATA_OUT, 8'hCC, 1, rd, lat);
    chk("abort_nordy", 32'(lat), 32'hFFFF_FFFF);
    chk("abort_keep", 32'(gpio_o1), 32'h33);

    // reset pulse in the middle of a write
    wr_reg(0, ADDR_DATA_OUT, 8'h5A);
    @(posedge pclk); #1;
    psel_d[0] = 1'b1; penable_d[0] = 1'b0; pwrite_d[0] = 1'b1;
    paddr_d[0] = ADDR_DATA_OUT; pwdata_d[0] = 8'h3C;
    @(posedge pclk); #1 penable_d[0] = 1'b1;
    #5 presetn = 1'b0;
    #3 presetn = 1'b1;
    @(posedge pclk); #1;
    psel_d[0] = 1'b0; penable_d[0] = 1'b0; pwrite_d[0] = 1'b0;
    chk("mid_rst_o",  32'(gpio_o0),     32'h00);
    chk("mid_rst_oe", 32'(gpio_oe1),    32'h00);
    chk("mid_rst_rdy", 32'(bus0.pready), 32'h0);
    rd_reg(0, ADDR_DATA_OUT, rd);
    chk("mid_rst_rd", 32'(rd), 32'h00);

    // randomised traffic on both banks with wandering pins
    fork
      rand_txns(0, 150);
      rand_txns(1, 60);
      begin
        for (int i = 0; i < 300; i++) begin
          repeat ($urandom_range(1, 4)) @(posedge pclk);
          #1 gpio_i = DW'($urandom);
        end
      end
    join
    repeat (5) @(posedge pclk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/gpio_apb_bank.md
Name: gpio_apb_bank

Overview:
- APB responder for one GPIO bank of the SPI GPIO expander. It sits on the far side of the SPI-to-APB bridge, with one instance per `psel` bit.
- Holds the output, direction and interrupt registers for `DATA_WIDTH` pins.
- Synchronises the input pins and detects edges on them.
- Answers APB reads and writes with a programmable number of wait states, asserting `pready` for the bridge to sample.

Parameters:
- `DATA_WIDTH`, 8: pins per bank; also the width of the APB data bus.
- `ADDR_WIDTH`, 3: APB address width; gives 8 register slots.
- `WAIT_STATES`, 0: extra access-phase cycles before `pready` (range 0..7).

Ports:
- `pclk`  in  1  APB/system clock.
- `presetn`  in  1  Asynchronous, active-low reset.
- `psel`  in  1  Select for this bank (one bit of the bridge's `psel` vector).
- `penable`  in  1  APB enable.
- `pwrite`  in  1  1 = write, 0 = read.
- `paddr`  in  `ADDR_WIDTH`  Register address.
- `pwdata`  in  `DATA_WIDTH`  Write data.
- `prdata`  out  `DATA_WIDTH`  Read data; valid only while `pready` = 1, otherwise 0.
- `pready`  out  1  Transfer-complete strobe.
- `gpio_i`  in  `DATA_WIDTH`  Asynchronous pin inputs.
- `gpio_o`  out  `DATA_WIDTH`  Pin output values (= `DATA_OUT`).
- `gpio_oe`  out  `DATA_WIDTH`  Per-pin output enable (= `DIR`, 1 = output).
- `irq`  out  1  OR-reduction of `IRQ_STATUS`.

Behaviour:
- Reset (async, `presetn` = 0): every register is 0.
  - Outputs: `prdata`=0, `pready`=0, `gpio_o`=0, `gpio_oe`=0, `irq`=0.
  - Internal: both synchroniser stages = 0; FSM in IDLE; wait counter = 0.
  - Reset asserted mid-transfer aborts it with no register update.
- Register map:
  - 0 `DATA_OUT`: RW.
  - 1 `DIR`: RW.
  - 2 `DATA_IN`: RO, synchronised `gpio_i`.
  - 3 `RISE_EN`: RW.
  - 4 `FALL_EN`: RW.
  - 5 `IRQ_STATUS`: read; write-1-to-clear.
  - 6 `OUT_SET`: write ORs the data into `DATA_OUT`; reads 0.
  - 7 `OUT_CLR`: write clears the written bits in `DATA_OUT`; reads 0.
  - Writes to RO slots are ignored.
- FSM has three states: IDLE, WAIT, RESP.
  - IDLE: on `psel` & !`penable` (setup phase), go to RESP if `WAIT_STATES`=0, else go to WAIT with the counter cleared.
  - WAIT: counter increments each cycle; when counter = `WAIT_STATES`-1, go to RESP.
  - RESP: `pready`=1 for exactly one cycle. On the `pclk` edge ending RESP, if `pwrite`, commit `pwdata` to `paddr`. Then return to IDLE.
  - In WAIT or RESP, if `psel`=0: return to IDLE, no write, `pready` stays 0.
  - `pready` and `prdata` are registered.
- Latency: `pready` goes high in the first access cycle when `WAIT_STATES`=0; in general, `WAIT_STATES` cycles after the first access cycle.
- Read data: `prdata` is loaded on the transition into RESP from the register addressed by `paddr`, using the value current at that edge. It returns to 0 when leaving RESP. Reads have no side effects.
- Input path:
  - `gpio_i` passes through a 2-flop synchroniser, then a `prev` register.
  - `rise` = sync & ~`prev`; `fall` = ~sync & `prev`.
  - `IRQ_STATUS` |= (`rise` & `RISE_EN`) | (`fall` & `FALL_EN`) every cycle.
  - Pin-to-`DATA_IN` latency is 2 cycles; pin-to-`IRQ_STATUS` latency is 3 cycles.
- Simultaneous events:
  - A hardware set of a status bit wins over a W1C on the same bit in the same cycle.
  - Edge detection runs regardless of `DIR`, so output pins loop back if the pad reflects them.
- `DATA_WIDTH` bits map 1:1 to `pwdata`/`prdata`. There is no `pslverr`; out-of-range access is impossible at 3 address bits.

Decomposition:
- Package `gpio_bank_pkg` holds:
  - register address constants `ADDR_DATA_OUT` .. `ADDR_OUT_CLR` (0..7);
  - the FSM state encoding (IDLE=0, WAIT=1, RESP=2).
- One sub-module, `gpio_sync_edge`: 2-flop synchroniser plus `prev` register, producing `sync`, `rise` and `fall` vectors. Reused by later banks.

Test Plan:
- Reset: pulse `presetn` low for 3 ns mid-write → `gpio_o`=00, `gpio_oe`=00, `pready`=0, and reading addr 0 afterwards returns 00.
- Zero-wait write/read:
  - write addr 1 = 0xF0, then addr 0 = 0xA5 → `gpio_oe`=F0, `gpio_o`=A5;
  - read addr 0 → `prdata`=A5 with `pready` high in the first access cycle.
- Set/clear: with `DATA_OUT`=A5, write addr 6 = 0x0A, then addr 7 = 0x81 → `gpio_o`=AF, then 2E; reads of addr 6/7 return 00.
- Input and interrupt:
  - `RISE_EN`=0x01, `FALL_EN`=0x80, `gpio_i` 00→81→00;
  - → `DATA_IN` reads 81 two cycles after the change;
  - `IRQ_STATUS`=01 then 81, `irq`=1;
  - write addr 5 = 0x01 → status 80; write 0x80 → status 00, `irq`=0.
- Race: W1C of bit 0 in the same cycle as a new rise on pin 0 → bit 0 stays 1.
- Wait states and abort:
  - `WAIT_STATES`=3: read addr 1 → `pready` rises 3 cycles after the first access cycle, `prdata`=F0.
  - Deassert `psel` during WAIT on a write of addr 0 → no `pready`, `DATA_OUT` unchanged.
